// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings, the SRAM slave FSM state type and the byte-lane
// strobe helper used when a transfer is accepted.
package ahb_lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam int MAX_STRB_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } ahb_state_e;

    // Lanes touched by an aligned transfer; bits above DATA_W/8 are always zero.
    function automatic logic [MAX_STRB_W-1:0] size_to_strb(
        input logic [2:0]  hsize,
        input logic [2:0]  addr_lsbs,
        input int unsigned data_w
    );
        logic [MAX_STRB_W-1:0] base;
        logic [15:0]           valid;
        logic [2:0]            offset;
        int unsigned           nbytes;
        nbytes = data_w / 8;
        valid  = (16'd1 << nbytes) - 16'd1;
        offset = addr_lsbs & 3'(nbytes - 1);
        case (hsize)
            HSIZE_BYTE: base = 8'h01;
            HSIZE_HALF: base = 8'h03;
            HSIZE_WORD: base = 8'h0F;
            default:    base = 8'hFF;
        endcase
        return (base << offset) & valid[7:0];
    endfunction

endpackage

// File: rtl/ahb_sram_bytelane_mem.sv
// DEPTH x DATA_W storage with per-byte write enables and an asynchronous read port.
// The array has no reset so its contents survive a bus reset.
module ahb_sram_bytelane_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [DATA_W/8-1:0]        be,
    input  logic [$clog2(DEPTH)-1:0]   addr,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DATA_W-1:0]          rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DATA_W / 8; b++) begin
                if (be[b]) begin
                    mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_slave_ws.sv
// AHB-Lite SRAM slave with byte-lane writes, programmable wait states and a two-cycle
// ERROR response; the address phase is registered on accept and completed later.
module ahb_sram_slave_ws
    import ahb_lite_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [DATA_W-1:0] HRDATA
);

    localparam int STRB_W    = DATA_W / 8;
    localparam int LANE_BITS = $clog2(STRB_W);
    localparam int IDX_W     = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    ahb_state_e        state_q, state_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic              dp_valid_q;
    logic              dp_write_q;
    logic [IDX_W-1:0]  dp_index_q;
    logic [STRB_W-1:0] dp_strb_q;

    logic              slave_ready;
    logic              accept;
    logic              completion;
    logic              mem_we;
    logic              size_bad;
    logic              misaligned;
    logic              out_of_range;
    logic              req_bad;
    logic [7:0]        align_mask;
    logic [7:0]        strb_full;
    logic [DATA_W-1:0] mem_rdata;
    logic              unused_bits;

    // A new address phase is only taken while this slave is not stalling the bus.
    assign slave_ready = (state_q == ST_IDLE) || (state_q == ST_ERR2);
    assign accept      = HSEL && HTRANS[1] && HREADY && slave_ready;
    assign completion  = (state_q == ST_IDLE) && dp_valid_q;
    assign mem_we      = completion && dp_write_q;

    assign align_mask   = (8'd1 << HSIZE) - 8'd1;
    assign size_bad     = HSIZE > 3'(LANE_BITS);
    assign misaligned   = |(HADDR[2:0] & align_mask[2:0]);
    assign out_of_range = (HADDR >> (LANE_BITS + IDX_W)) != '0;
    assign req_bad      = size_bad || misaligned || out_of_range;
    assign strb_full    = size_to_strb(HSIZE, HADDR[2:0], DATA_W);
    assign unused_bits  = ^{HTRANS[0], strb_full};

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Completion of an OKAY transfer always happens in IDLE with dp_valid set,
    // whether it arrived there straight from accept or at the end of WAIT.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        HREADYOUT  = 1'b1;
        HRESP      = HRESP_OKAY;
        case (state_q)
            ST_IDLE, ST_ERR2: begin
                if (state_q == ST_ERR2) begin
                    HRESP = HRESP_ERROR;
                end
                state_d = ST_IDLE;
                if (accept) begin
                    if (req_bad) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                HREADYOUT  = 1'b0;
                wait_cnt_d = wait_cnt_q - 4'd1;
                if (wait_cnt_q <= 4'd1) begin
                    state_d    = ST_IDLE;
                    wait_cnt_d = '0;
                end
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
                state_d   = ST_ERR2;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_index_q <= '0;
            dp_strb_q  <= '0;
        end else if (accept) begin
            dp_valid_q <= !req_bad;
            dp_write_q <= HWRITE;
            dp_index_q <= HADDR[LANE_BITS +: IDX_W];
            dp_strb_q  <= strb_full[STRB_W-1:0];
        end else if (completion) begin
            dp_valid_q <= 1'b0;
        end
    end

    assign HRDATA = (completion && !dp_write_q) ? mem_rdata : '0;

    ahb_sram_bytelane_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (HCLK),
        .we    (mem_we),
        .be    (dp_strb_q),
        .addr  (dp_index_q),
        .wdata (HWDATA),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_ahb_sram_slave_ws.sv
// Bench for ahb_sram_slave_ws: three instances (32b/0 waits, 32b/3 waits, 64b/1 wait)
// driven by a pipelined AHB-Lite master and compared against a byte-level memory model.
module tb_ahb_sram_slave_ws;

    typedef struct packed {
        logic        sel;
        logic [1:0]  trans;
        logic        write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [63:0] wdata;
    } xfer_t;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        stall;
    int          cur;
    logic        busSel;
    logic [31:0] busAddr;
    logic [1:0]  busTrans;
    logic        busWrite;
    logic [2:0]  busSize;
    logic [63:0] busWdata;

    logic        selA, selB, selC;
    logic        hreadyA, hreadyB, hreadyC;
    logic        rdyA, rdyB, rdyC;
    logic        respA, respB, respC;
    logic [31:0] rdataA, rdataB;
    logic [63:0] rdataC;

    logic [63:0] modelMem [3][256];
    xfer_t       xq [$];
    int          nChecks = 0;
    int          nPass   = 0;
    int          nFail   = 0;

    always #5 HCLK = ~HCLK;

    assign selA    = busSel && (cur == 0);
    assign selB    = busSel && (cur == 1);
    assign selC    = busSel && (cur == 2);
    assign hreadyA = rdyA && !stall;
    assign hreadyB = rdyB && !stall;
    assign hreadyC = rdyC && !stall;

    ahb_sram_slave_ws #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .WAIT_STATES(0)) dutA (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(selA), .HADDR(busAddr), .HTRANS(busTrans),
        .HWRITE(busWrite), .HSIZE(busSize), .HWDATA(busWdata[31:0]), .HREADY(hreadyA),
        .HREADYOUT(rdyA), .HRESP(respA), .HRDATA(rdataA));

    ahb_sram_slave_ws #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .WAIT_STATES(3)) dutB (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(selB), .HADDR(busAddr), .HTRANS(busTrans),
        .HWRITE(busWrite), .HSIZE(busSize), .HWDATA(busWdata[31:0]), .HREADY(hreadyB),
        .HREADYOUT(rdyB), .HRESP(respB), .HRDATA(rdataB));

    ahb_sram_slave_ws #(.DATA_W(64), .ADDR_W(32), .DEPTH(256), .WAIT_STATES(1)) dutC (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(selC), .HADDR(busAddr), .HTRANS(busTrans),
        .HWRITE(busWrite), .HSIZE(busSize), .HWDATA(busWdata), .HREADY(hreadyC),
        .HREADYOUT(rdyC), .HRESP(respC), .HRDATA(rdataC));

    function automatic int bytesOf(input int d);
        return (d == 2) ? 8 : 4;
    endfunction

    function automatic int waitsOf(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 3 : 1);
    endfunction

    function automatic int lgOf(input int d);
        return (d == 2) ? 3 : 2;
    endfunction

    function automatic bit isBad(input int d, input xfer_t x);
        int nb;
        nb = bytesOf(d);
        if (int'(x.size) > lgOf(d)) return 1'b1;
        if ((x.addr % (32'd1 << x.size)) != 0) return 1'b1;
        if ((x.addr / nb) >= 256) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void modelWrite(input int d, input xfer_t x);
        int nb, idx, off;
        nb  = bytesOf(d);
        idx = int'(x.addr / nb);
        off = int'(x.addr % nb);
        for (int i = 0; i < (1 << x.size); i++) begin
            modelMem[d][idx][(off + i)*8 +: 8] = x.wdata[(off + i)*8 +: 8];
        end
    endfunction

    function automatic void pushX(input logic sel, input logic [1:0] trans, input logic write,
                                  input logic [31:0] addr, input logic [2:0] size,
                                  input logic [63:0] wdata);
        xfer_t x;
        x.sel = sel; x.trans = trans; x.write = write;
        x.addr = addr; x.size = size; x.wdata = wdata;
        xq.push_back(x);
    endfunction

    task automatic sampleOutputs(input int d, output logic rdy, output logic resp,
                                 output logic [63:0] rdata);
        case (d)
            0:       begin rdy = rdyA; resp = respA; rdata = {32'd0, rdataA}; end
            1:       begin rdy = rdyB; resp = respB; rdata = {32'd0, rdataB}; end
            default: begin rdy = rdyC; resp = respC; rdata = rdataC;          end
        endcase
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else begin
            nFail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Runs the queued transfers through DUT d as a pipelined master; must be
    // entered just after a rising edge with the bus idle and no data phase open.
    task automatic applyStimulus(input int d);
        int          ai, guard, dpCycle, nb, ws;
        bit          dpActive, dpErr;
        xfer_t       dp, nx;
        logic        rdy, resp, expRdy, expResp;
        logic [63:0] rdata, expData;
        nb = bytesOf(d); ws = waitsOf(d);
        cur = d; ai = 0; guard = 0; dpActive = 0; dpErr = 0; dpCycle = 0; dp = '0;
        while ((ai < xq.size() || dpActive) && guard < 4000) begin
            guard++;
            if (ai < xq.size()) begin
                busSel = xq[ai].sel; busTrans = xq[ai].trans; busWrite = xq[ai].write;
                busAddr = xq[ai].addr; busSize = xq[ai].size;
            end else begin
                busSel = 1'b0; busTrans = 2'b00;
            end
            busWdata = dpActive ? dp.wdata : 64'd0;
            @(negedge HCLK);
            sampleOutputs(d, rdy, resp, rdata);
            if (!dpActive) begin
                expRdy = 1'b1; expResp = 1'b0; expData = '0;
            end else if (dpErr) begin
                expRdy = (dpCycle == 1); expResp = 1'b1; expData = '0;
            end else begin
                expRdy  = (dpCycle == ws); expResp = 1'b0;
                expData = (!dp.write && dpCycle == ws) ? modelMem[d][dp.addr / nb] : 64'd0;
            end
            checkOutput($sformatf("dut%0d_cyc%0d_hreadyout", d, guard), rdy, expRdy);
            checkOutput($sformatf("dut%0d_cyc%0d_hresp", d, guard), resp, expResp);
            checkOutput($sformatf("dut%0d_cyc%0d_hrdata", d, guard), rdata, expData);
            @(posedge HCLK); #1;
            if (rdy === 1'b1) begin
                if (dpActive && !dpErr && dp.write) modelWrite(d, dp);
                dpActive = 0;
                if (ai < xq.size()) begin
                    nx = xq[ai];
                    ai++;
                    if (nx.sel && nx.trans[1]) begin
                        dpActive = 1; dp = nx; dpErr = isBad(d, nx); dpCycle = 0;
                    end
                end
            end else if (dpActive) begin
                dpCycle++;
            end
        end
        checkOutput($sformatf("dut%0d_sequence_drained", d), 64'(ai < xq.size() || dpActive), 64'd0);
        busSel = 1'b0; busTrans = 2'b00;
        xq.delete();
    endtask

    initial begin
        logic        rdy, resp;
        logic [63:0] rdata;
        int          nb, lg, sz, word, off, r, t;
        logic [31:0] a;
        logic [1:0]  tr;

        HRESET = 1'b1; stall = 1'b0; cur = 0;
        busSel = 1'b0; busAddr = '0; busTrans = 2'b00; busWrite = 1'b0; busSize = '0; busWdata = '0;
        for (int d = 0; d < 3; d++) for (int i = 0; i < 256; i++) modelMem[d][i] = '0;

        repeat (3) @(posedge HCLK);
        #1;
        for (int d = 0; d < 3; d++) begin
            sampleOutputs(d, rdy, resp, rdata);
            checkOutput($sformatf("reset_dut%0d_hreadyout", d), rdy, 1);
            checkOutput($sformatf("reset_dut%0d_hresp", d), resp, 0);
            checkOutput($sformatf("reset_dut%0d_hrdata", d), rdata, 0);
        end
        #2 HRESET = 1'b0;
        @(posedge HCLK); #1;

        // Give every DUT 16 known words so later reads have defined contents.
        for (int d = 0; d < 3; d++) begin
            nb = bytesOf(d);
            for (int w = 0; w < 16; w++)
                pushX(1, 2'b10, 1, 32'(w * nb), 3'(lgOf(d)), {$urandom, $urandom});
            applyStimulus(d);
        end

        $display("[TB] back-to-back write/read and byte-lane merge, zero waits");
        pushX(1, 2'b10, 1, 32'h10, 3'd2, 64'hDEADBEEF);
        pushX(1, 2'b10, 0, 32'h10, 3'd2, 64'd0);
        pushX(1, 2'b10, 1, 32'h10, 3'd2, 64'h11223344);
        pushX(1, 2'b10, 1, 32'h13, 3'd0, 64'hAA000000);
        pushX(1, 2'b10, 0, 32'h10, 3'd2, 64'd0);
        applyStimulus(0);

        $display("[TB] three wait states with pipelined next address");
        pushX(1, 2'b10, 1, 32'h20, 3'd2, 64'h0BADF00D);
        pushX(1, 2'b10, 0, 32'h20, 3'd2, 64'd0);
        pushX(1, 2'b11, 0, 32'h24, 3'd2, 64'd0);
        pushX(1, 2'b11, 1, 32'h26, 3'd1, 64'h5A5A0000);
        pushX(1, 2'b10, 0, 32'h24, 3'd2, 64'd0);
        applyStimulus(1);

        $display("[TB] out-of-range, misaligned and oversize requests");
        pushX(1, 2'b10, 1, 32'h400, 3'd2, 64'hFFFFFFFF);
        pushX(1, 2'b10, 0, 32'h000, 3'd2, 64'd0);
        pushX(1, 2'b10, 1, 32'h001, 3'd1, 64'h0000BEEF);
        pushX(1, 2'b10, 0, 32'h000, 3'd3, 64'd0);
        pushX(1, 2'b10, 0, 32'h000, 3'd2, 64'd0);
        applyStimulus(0);
        pushX(1, 2'b10, 1, 32'h008, 3'd3, 64'h0123456789ABCDEF);
        pushX(1, 2'b10, 0, 32'h008, 3'd3, 64'd0);
        pushX(1, 2'b10, 1, 32'h800, 3'd3, 64'hFFFFFFFFFFFFFFFF);
        pushX(1, 2'b10, 1, 32'h00C, 3'd2, 64'h7777777700000000);
        pushX(1, 2'b10, 0, 32'h002, 3'd2, 64'd0);
        pushX(1, 2'b10, 0, 32'h008, 3'd3, 64'd0);
        pushX(1, 2'b10, 0, 32'h000, 3'd3, 64'd0);
        applyStimulus(2);

        $display("[TB] address phase while another slave holds HREADY low");
        cur = 0; stall = 1'b1;
        busSel = 1'b1; busTrans = 2'b10; busWrite = 1'b1; busAddr = 32'h20; busSize = 3'd2;
        busWdata = 64'h55555555;
        @(negedge HCLK);
        sampleOutputs(0, rdy, resp, rdata);
        checkOutput("stall_idle_hreadyout", rdy, 1);
        @(posedge HCLK); #1;
        busSel = 1'b0; busTrans = 2'b00; stall = 1'b0;
        @(negedge HCLK);
        sampleOutputs(0, rdy, resp, rdata);
        checkOutput("stall_no_accept_hreadyout", rdy, 1);
        checkOutput("stall_no_accept_hresp", resp, 0);
        @(posedge HCLK); #1;
        pushX(1, 2'b10, 0, 32'h20, 3'd2, 64'd0);
        applyStimulus(0);

        $display("[TB] reset during the wait states of a write");
        cur = 1;
        busSel = 1'b1; busTrans = 2'b10; busWrite = 1'b1; busAddr = 32'h8; busSize = 3'd2;
        busWdata = 64'hCAFEF00D;
        @(posedge HCLK); #1;
        busSel = 1'b0; busTrans = 2'b00;
        @(negedge HCLK);
        sampleOutputs(1, rdy, resp, rdata);
        checkOutput("rst_mid_wait_hreadyout", rdy, 0);
        #1 HRESET = 1'b1;
        #1;
        sampleOutputs(1, rdy, resp, rdata);
        checkOutput("rst_async_hreadyout", rdy, 1);
        checkOutput("rst_async_hresp", resp, 0);
        checkOutput("rst_async_hrdata", rdata, 0);
        @(posedge HCLK);
        @(posedge HCLK);
        #2 HRESET = 1'b0;
        @(posedge HCLK); #1;
        pushX(1, 2'b10, 0, 32'h8, 3'd2, 64'd0);
        pushX(1, 2'b10, 1, 32'h8, 3'd1, 64'h00001234);
        pushX(1, 2'b10, 0, 32'h8, 3'd2, 64'd0);
        applyStimulus(1);

        $display("[TB] randomized traffic with final read-back");
        for (int d = 0; d < 3; d++) begin
            nb = bytesOf(d); lg = lgOf(d);
            for (int n = 0; n < 40; n++) begin
                r    = int'($urandom_range(0, 9));
                sz   = int'($urandom_range(0, lg));
                word = int'($urandom_range(0, 15));
                off  = int'($urandom_range(0, nb - 1)) & ~((1 << sz) - 1);
                a    = 32'(word * nb + off);
                if (r == 0) a = 32'((256 + word) * nb);
                if (r == 1) sz = lg + 1;
                if (r == 2 && sz > 0) a = a | 32'd1;
                t  = int'($urandom_range(0, 9));
                tr = (t == 0) ? 2'b00 : ((t == 1) ? 2'b01 : ((t < 6) ? 2'b10 : 2'b11));
                pushX(($urandom_range(0, 9) != 0), tr, 1'($urandom_range(0, 1)), a, 3'(sz),
                      {$urandom, $urandom});
            end
            for (int w = 0; w < 16; w++)
                pushX(1, 2'b10, 0, 32'(w * nb), 3'(lg), 64'd0);
            applyStimulus(d);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
